output_deskew_buffer: RTL and testbench

OUTPUT_DESKEW_BUFFER -- requirements
Module: output_deskew_buffer

---
 rtl/sa_pkg.sv | 12 +
 rtl/output_deskew_buffer_if.sv | 26 ++
 rtl/lane_delay.sv | 48 ++++
 rtl/output_deskew_buffer.sv | 125 ++++++++++++
 tb/tb_output_deskew_buffer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared defaults and row types for the systolic-array output path.
package sa_pkg;

  localparam int SA_RES_WIDTH  = 8;
  localparam int SA_NUM_COLS   = 3;
  localparam int SA_ADDR_WIDTH = 2;

  // One column result lane and one full row at the default geometry.
  typedef logic [SA_RES_WIDTH-1:0] lane_t;
  typedef lane_t [SA_NUM_COLS-1:0] row_t;

endpackage

// File: rtl/output_deskew_buffer_if.sv
// Bundle of the column-input and row-output signals of the deskew buffer.
// The master side produces column strobes and consumes rows; the slave side is the buffer.
interface output_deskew_buffer_if #(
  parameter int RES_WIDTH = 8,
  parameter int NUM_COLS  = 3
);
  logic [NUM_COLS-1:0]           col_valid;
  logic [NUM_COLS*RES_WIDTH-1:0] col_data;
  logic                          flush;
  logic                          ready;
  logic                          valid;
  logic [NUM_COLS*RES_WIDTH-1:0] data;
  logic                          full;
  logic                          overflow;
  logic                          skew_err;

  modport master (
    output col_valid, col_data, flush, ready,
    input  valid, data, full, overflow, skew_err
  );

  modport slave (
    input  col_valid, col_data, flush, ready,
    output valid, data, full, overflow, skew_err
  );
endinterface

// File: rtl/lane_delay.sv
// Fixed-length delay line for one column: valid and data travel together.
// DEPTH of 0 is a plain wire. Flush clears the in-flight valids only.
module lane_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : gPass
      logic pass_unused;
      assign pass_unused = &{1'b0, i_clk, i_rst_n, i_flush};
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : gPipe
      logic [DEPTH-1:0]            valid_q;
      logic [DEPTH-1:0][WIDTH-1:0] data_q;

      // Shift valid and data one stage per clock; flush empties the valid chain.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          if (i_flush) begin
            valid_q <= '0;
          end else begin
            valid_q[0] <= i_valid;
            for (int k = DEPTH - 1; k > 0; k--) valid_q[k] <= valid_q[k-1];
          end
          data_q[0] <= i_data;
          for (int k = DEPTH - 1; k > 0; k--) data_q[k] <= data_q[k-1];
        end
      end

      assign o_valid = valid_q[DEPTH-1];
      assign o_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/output_deskew_buffer.sv
// Realigns skewed systolic column results into rows and queues them in a
// first-word-fall-through FIFO. Optional feature macro: OUTBUF_RELU_EN
// (clamps negative signed lanes to zero before they enter the FIFO).
module output_deskew_buffer
  import sa_pkg::*;
#(
  parameter int RES_WIDTH  = SA_RES_WIDTH,
  parameter int NUM_COLS   = SA_NUM_COLS,
  parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_COLS-1:0]           i_col_valid,
  input  logic [NUM_COLS*RES_WIDTH-1:0] i_col_data,
  input  logic                          i_flush,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [NUM_COLS*RES_WIDTH-1:0] o_data,
  output logic                          o_full,
  output logic                          o_overflow,
  output logic                          o_skew_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef logic [NUM_COLS-1:0][RES_WIDTH-1:0] rowBits_t;

  logic [NUM_COLS-1:0]   alignValid;
  rowBits_t              alignData;
  rowBits_t              wrRow;
  rowBits_t              mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  skewErr_q, skewErr_d;
  logic                  rowReady, rowSkew, isFull, rdEn, wrEn;

  // Earlier columns wait longer so every lane of a row lines up with the last column.
  for (genvar c = 0; c < NUM_COLS; c++) begin : gCol
    lane_delay #(
      .DEPTH (NUM_COLS - 1 - c),
      .WIDTH (RES_WIDTH)
    ) uDelay (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_valid (i_col_valid[c]),
      .i_data  (i_col_data[c*RES_WIDTH +: RES_WIDTH]),
      .o_valid (alignValid[c]),
      .o_data  (alignData[c])
    );
  end

  // Row as it will be stored; negative lanes are clamped when the ReLU build is selected.
  always_comb begin
    wrRow = alignData;
`ifdef OUTBUF_RELU_EN
    for (int c = 0; c < NUM_COLS; c++) begin
      if (alignData[c][RES_WIDTH-1]) wrRow[c] = '0;
    end
`endif
  end

  // FIFO pointer/count bookkeeping and sticky error detection.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    skewErr_d  = skewErr_q;
    rowReady   = &alignValid;
    rowSkew    = (|alignValid) & ~rowReady;
    isFull     = (count_q == FULL_COUNT);
    rdEn       = (count_q != '0) & i_ready & ~i_flush;
    wrEn       = rowReady & ~i_flush & (~isFull | rdEn);

    if (i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (rowSkew) skewErr_d = 1'b1;
      if (rowReady && isFull && !rdEn) overflow_d = 1'b1;
      if (rdEn) rdPtr_d = rdPtr_q + 1'b1;
      if (wrEn) wrPtr_d = wrPtr_q + 1'b1;
      if (wrEn && !rdEn) count_d = count_q + 1'b1;
      else if (rdEn && !wrEn) count_d = count_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      skewErr_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      skewErr_q  <= skewErr_d;
    end
  end

  // Row storage is cleared on reset so the fall-through output is never unknown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wrEn) begin
      mem_q[wrPtr_q] <= wrRow;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_full     = isFull;
  assign o_data     = mem_q[rdPtr_q];
  assign o_overflow = overflow_q;
  assign o_skew_err = skewErr_q;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Self-checking bench for output_deskew_buffer (default geometry 8b x 3 columns,
// 4-row FIFO). Honours OUTBUF_RELU_EN in its reference model.
module tb_output_deskew_buffer;
  import sa_pkg::*;

  localparam int W = SA_RES_WIDTH;
  localparam int N = SA_NUM_COLS;
  localparam int D = 1 << SA_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  output_deskew_buffer_if #(.RES_WIDTH(W), .NUM_COLS(N)) busIf ();

  output_deskew_buffer #(
    .RES_WIDTH  (W),
    .NUM_COLS   (N),
    .ADDR_WIDTH (SA_ADDR_WIDTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_col_valid (busIf.col_valid),
    .i_col_data  (busIf.col_data),
    .i_flush     (busIf.flush),
    .i_ready     (busIf.ready),
    .o_valid     (busIf.valid),
    .o_data      (busIf.data),
    .o_full      (busIf.full),
    .o_overflow  (busIf.overflow),
    .o_skew_err  (busIf.skew_err)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: queue of stored rows, sticky flags, and the past N-1 input cycles.
  logic [N*W-1:0] modelQ[$];
  logic           modelOvf;
  logic           modelSkew;
  logic [N-1:0]   histV [1:N-1];
  logic [N*W-1:0] histD [1:N-1];

  // Upstream skew generator: column c of a row is emitted c cycles after column 0.
  logic           col1PendV, c2aV, c2bV;
  logic [W-1:0]   col1PendD, c2aD, c2bD;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [N*W-1:0] reluRow(input logic [N*W-1:0] r);
    logic [N*W-1:0] o;
    o = r;
`ifdef OUTBUF_RELU_EN
    for (int c = 0; c < N; c++) begin
      if ($signed(r[c*W +: W]) < 0) o[c*W +: W] = '0;
    end
`endif
    return o;
  endfunction

  task automatic clearPending();
    col1PendV = 1'b0; c2aV = 1'b0; c2bV = 1'b0;
    col1PendD = '0;   c2aD = '0;   c2bD = '0;
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf  = 1'b0;
    modelSkew = 1'b0;
    for (int k = 1; k < N; k++) begin
      histV[k] = '0;
      histD[k] = '0;
    end
  endtask

  // One clock edge of the reference behaviour.
  task automatic modelEdge(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic fl, input logic rdy);
    logic [N-1:0]   alV;
    logic [N*W-1:0] alD;
    logic           rd;
    int             sizeBefore;
    for (int c = 0; c < N; c++) begin
      int dl;
      dl = N - 1 - c;
      if (dl == 0) begin
        alV[c] = v[c];
        alD[c*W +: W] = d[c*W +: W];
      end else begin
        alV[c] = histV[dl][c];
        alD[c*W +: W] = histD[dl][c*W +: W];
      end
    end
    if (fl) begin
      modelQ.delete();
    end else begin
      sizeBefore = modelQ.size();
      rd = (sizeBefore != 0) && rdy;
      if (alV != '0 && alV != '1) modelSkew = 1'b1;
      if (rd) void'(modelQ.pop_front());
      if (alV == '1) begin
        if (sizeBefore < D || rd) modelQ.push_back(reluRow(alD));
        else modelOvf = 1'b1;
      end
    end
    for (int k = N - 1; k > 1; k--) begin
      histV[k] = fl ? '0 : histV[k-1];
      histD[k] = histD[k-1];
    end
    histV[1] = fl ? '0 : v;
    histD[1] = d;
  endtask

  task automatic checkAll();
    checkOutput("valid", busIf.valid, modelQ.size() != 0);
    checkOutput("full", busIf.full, modelQ.size() == D);
    checkOutput("overflow", busIf.overflow, modelOvf);
    checkOutput("skewErr", busIf.skew_err, modelSkew);
    if (modelQ.size() != 0) checkOutput("headRow", busIf.data, modelQ[0]);
  endtask

  // Drive one cycle: optionally start a row, mask individual strobes, flush, ready.
  task automatic applyStimulus(input logic start, input logic [N*W-1:0] row, input logic [N-1:0] dropMask,
                               input logic fl, input logic rdy);
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    v = {c2bV, col1PendV, start} & ~dropMask;
    d = {c2bD, col1PendD, row[W-1:0]};
    c2bV = c2aV;  c2bD = c2aD;
    c2aV = start; c2aD = row[3*W-1:2*W];
    col1PendV = start; col1PendD = row[2*W-1:W];
    if (fl) clearPending();
    busIf.col_valid = v;
    busIf.col_data  = d;
    busIf.flush     = fl;
    busIf.ready     = rdy;
    modelEdge(v, d, fl, rdy);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 1'b0, rdy);
  endtask

  // Asynchronous reset pulse taken between clock edges; outputs must clear at once.
  task automatic doReset();
    rstN = 1'b0;
    busIf.col_valid = '0;
    busIf.col_data  = '0;
    busIf.flush     = 1'b0;
    busIf.ready     = 1'b0;
    clearPending();
    modelReset();
    #1;
    checkOutput("rstValid", busIf.valid, 1'b0);
    checkOutput("rstFull", busIf.full, 1'b0);
    checkOutput("rstData", busIf.data, 24'h0);
    checkOutput("rstOverflow", busIf.overflow, 1'b0);
    checkOutput("rstSkewErr", busIf.skew_err, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  logic [N*W-1:0] rows [0:4];
  logic [N*W-1:0] expRow;

  initial begin
    doReset();

    // A single skewed row 0x332211 appears one cycle after its last strobe.
    applyStimulus(1'b1, 24'h332211, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("notYetValid", busIf.valid, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("deskewValid", busIf.valid, 1'b1);
    checkOutput("deskewRow", busIf.data, reluRow(24'h332211));
    idle(1, 1'b1);

    // Five rows with no reader: four stored, fifth dropped, then drained in order.
    for (int i = 0; i < 5; i++) begin
      rows[i] = 24'h102030 + 24'h010101 * i;
      applyStimulus(1'b1, rows[i], '0, 1'b0, 1'b0);
    end
    idle(2, 1'b0);
    checkOutput("fullAfter4", busIf.full, 1'b1);
    checkOutput("overflow5th", busIf.overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainOrder", busIf.data, rows[i]);
      idle(1, 1'b1);
    end
    checkOutput("drainedEmpty", busIf.valid, 1'b0);

    // Full FIFO with a read in the write cycle accepts the new row without overflow.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, rows[i], '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 24'h0A0B0C, '0, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("fullStays", busIf.full, 1'b1);
    checkOutput("noOverflow", busIf.overflow, 1'b0);
    checkOutput("headAfterPass", busIf.data, rows[1]);
    idle(5, 1'b1);

    // Missing column-1 strobe flags a skew error and stores nothing.
    applyStimulus(1'b1, 24'h445566, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 3'b010, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("skewFlag", busIf.skew_err, 1'b1);
    checkOutput("skewNoWrite", busIf.valid, 1'b0);

    // Flush with three rows stored and one in flight empties everything.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, rows[i], '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 24'h778899, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("flushEmpty", busIf.valid, 1'b0);
    idle(3, 1'b0);
    checkOutput("inFlightDropped", busIf.valid, 1'b0);

    // Reset pulse in the middle of a row.
    applyStimulus(1'b1, 24'h123456, '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b1, 24'h654321, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    doReset();
    idle(3, 1'b0);

    // Signed lanes: lane0 negative, lane1 positive.
    applyStimulus(1'b1, 24'h7F05F0, '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    expRow = busIf.data;
`ifdef OUTBUF_RELU_EN
    checkOutput("reluLane0", expRow[7:0], 8'h00);
`else
    checkOutput("reluLane0", expRow[7:0], 8'hF0);
`endif
    checkOutput("reluLane1", expRow[15:8], 8'h05);
    idle(2, 1'b1);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] mask;
      mask = ($urandom_range(0, 15) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      applyStimulus(1'($urandom_range(0, 1)), 24'($urandom), mask,
                    1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
    end
    idle(8, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
